// File: rtl/memoria_programa_dp.sv
// Dual-port program memory: byte-enable load port, fetch read port, clear sweep after reset.
// Optional per-column even parity is enabled by defining MEM_PROG_PARITY_EN.
module memoria_programa_dp #(
  parameter int                            NB_COL          = 4,
  parameter int                            COL_WIDTH       = 8,
  parameter int                            RAM_DEPTH       = 2048,
  parameter string                         RAM_PERFORMANCE = "LOW_LATENCY",
  parameter logic [NB_COL*COL_WIDTH-1:0]   FILL_VALUE      = {(NB_COL*COL_WIDTH){1'b1}},
  localparam int                           RAM_WIDTH       = NB_COL*COL_WIDTH,
  localparam int                           ADDR_W          = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_wr_en,
  input  logic [ADDR_W-1:0]    i_wr_addr,
  input  logic [NB_COL-1:0]    i_wr_be,
  input  logic [RAM_WIDTH-1:0] i_wr_data,
  input  logic                 i_rd_en,
  input  logic [ADDR_W-1:0]    i_rd_addr,
  input  logic                 i_rd_regce,
  output logic [RAM_WIDTH-1:0] o_rd_data,
  output logic                 o_rd_valid,
  output logic                 o_busy,
  output logic                 o_clear_done,
  output logic                 o_led,
  output logic                 o_parity_err
);

  localparam bit                HIGH_PERF = (RAM_PERFORMANCE == "HIGH_PERFORMANCE");
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH-1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   cnt;
  logic                busy;
  logic                done;

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

  logic sweep_we;
  logic wr_ok;
  logic rd_ok;
  logic rd_in_range;

`ifdef MEM_PROG_PARITY_EN
  logic [NB_COL-1:0] par [RAM_DEPTH];

  function automatic logic [NB_COL-1:0] col_parity(input logic [RAM_WIDTH-1:0] word);
    logic [NB_COL-1:0] p;
    for (int k = 0; k < NB_COL; k++) p[k] = ^word[k*COL_WIDTH +: COL_WIDTH];
    return p;
  endfunction
`endif

  assign sweep_we    = (state == CLEAR) && !i_reset;
  assign wr_ok       = !busy && i_wr_en && (int'(i_wr_addr) < RAM_DEPTH);
  assign rd_ok       = !busy && i_rd_en;
  assign rd_in_range = int'(i_rd_addr) < RAM_DEPTH;

  // Control FSM: the sweep counter walks 0..RAM_DEPTH-1 once per reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= CLEAR;
      cnt   <= '0;
      busy  <= 1'b1;
      done  <= 1'b0;
    end else if (state == CLEAR) begin
      if (cnt == LAST_ADDR) begin
        state <= READY;
        cnt   <= '0;
        busy  <= 1'b0;
        done  <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Storage: sweep fill has priority; loader writes only touch enabled columns
  always_ff @(posedge i_clk) begin
    if (sweep_we) begin
      mem[cnt] <= FILL_VALUE;
`ifdef MEM_PROG_PARITY_EN
      par[cnt] <= col_parity(FILL_VALUE);
`endif
    end else if (wr_ok) begin
      for (int k = 0; k < NB_COL; k++) begin
        if (i_wr_be[k]) begin
          mem[i_wr_addr][k*COL_WIDTH +: COL_WIDTH] <= i_wr_data[k*COL_WIDTH +: COL_WIDTH];
`ifdef MEM_PROG_PARITY_EN
          par[i_wr_addr][k] <= ^i_wr_data[k*COL_WIDTH +: COL_WIDTH];
`endif
        end
      end
    end
  end

  // Stage p0: array read (read-first against a same-edge write)
  logic [RAM_WIDTH-1:0] data_p0;
  logic                 vld_p0;
  logic                 perr_p0;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      data_p0 <= '0;
      vld_p0  <= 1'b0;
      perr_p0 <= 1'b0;
    end else begin
      vld_p0 <= rd_ok;
      if (rd_ok) data_p0 <= rd_in_range ? mem[i_rd_addr] : FILL_VALUE;
`ifdef MEM_PROG_PARITY_EN
      perr_p0 <= rd_ok && rd_in_range && (col_parity(mem[i_rd_addr]) != par[i_rd_addr]);
`else
      perr_p0 <= 1'b0;
`endif
    end
  end

  // Stage p1: optional output register gated by i_rd_regce
  logic [RAM_WIDTH-1:0] data_p1;
  logic                 vld_p1;
  logic                 perr_p1;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      data_p1 <= '0;
      vld_p1  <= 1'b0;
      perr_p1 <= 1'b0;
    end else if (!busy && i_rd_regce) begin
      data_p1 <= data_p0;
      vld_p1  <= vld_p0;
      perr_p1 <= perr_p0;
    end
  end

  assign o_rd_data    = HIGH_PERF ? data_p1 : data_p0;
  assign o_rd_valid   = HIGH_PERF ? vld_p1  : vld_p0;
  assign o_parity_err = HIGH_PERF ? perr_p1 : perr_p0;
  assign o_busy       = busy;
  assign o_clear_done = done;
  assign o_led        = done;

endmodule

// File: tb/tb_memoria_programa_dp.sv
// Directed bench for memoria_programa_dp: three instances (16-word low latency,
// 16-word high performance, 12-word low latency) share one stimulus stream.
module tb_memoria_programa_dp;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic        rd_regce;

  logic [31:0] ll_data, hp_data, oor_data;
  logic        ll_vld, hp_vld, oor_vld;
  logic        ll_busy, hp_busy, oor_busy;
  logic        ll_done, hp_done, oor_done;
  logic        ll_led, hp_led, oor_led;
  logic        ll_perr, hp_perr, oor_perr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  memoria_programa_dp #(.NB_COL(4), .COL_WIDTH(8), .RAM_DEPTH(16),
    .RAM_PERFORMANCE("LOW_LATENCY"), .FILL_VALUE(32'hFFFF_FFFF)) u_ll (
    .i_clk(clk), .i_reset(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_be(wr_be),
    .i_wr_data(wr_data), .i_rd_en(rd_en), .i_rd_addr(rd_addr), .i_rd_regce(rd_regce),
    .o_rd_data(ll_data), .o_rd_valid(ll_vld), .o_busy(ll_busy), .o_clear_done(ll_done),
    .o_led(ll_led), .o_parity_err(ll_perr));

  memoria_programa_dp #(.NB_COL(4), .COL_WIDTH(8), .RAM_DEPTH(16),
    .RAM_PERFORMANCE("HIGH_PERFORMANCE"), .FILL_VALUE(32'hFFFF_FFFF)) u_hp (
    .i_clk(clk), .i_reset(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_be(wr_be),
    .i_wr_data(wr_data), .i_rd_en(rd_en), .i_rd_addr(rd_addr), .i_rd_regce(rd_regce),
    .o_rd_data(hp_data), .o_rd_valid(hp_vld), .o_busy(hp_busy), .o_clear_done(hp_done),
    .o_led(hp_led), .o_parity_err(hp_perr));

  memoria_programa_dp #(.NB_COL(4), .COL_WIDTH(8), .RAM_DEPTH(12),
    .RAM_PERFORMANCE("LOW_LATENCY"), .FILL_VALUE(32'hFFFF_FFFF)) u_oor (
    .i_clk(clk), .i_reset(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_be(wr_be),
    .i_wr_data(wr_data), .i_rd_en(rd_en), .i_rd_addr(rd_addr), .i_rd_regce(rd_regce),
    .o_rd_data(oor_data), .o_rd_valid(oor_vld), .o_busy(oor_busy), .o_clear_done(oor_done),
    .o_led(oor_led), .o_parity_err(oor_perr));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycles o_busy stays high on the 16-word instance, counting the sample right after reset
  task automatic count_busy(output int n);
    n = 1;
    while (ll_busy === 1'b1 && n < 100) begin
      tick();
      if (ll_busy === 1'b1) n++;
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
  endtask

  int n;

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0; rd_regce = 1'b1;

    // Scenario 1: sweep after a one-cycle reset pulse
    tick();
    rst = 1'b0;
    chk("rst_busy", ll_busy, 1'b1);
    chk("rst_done", ll_done, 1'b0);
    chk("rst_led", ll_led, 1'b0);
    chk("rst_data", ll_data, 32'h0);
    chk("rst_vld", ll_vld, 1'b0);
    chk("rst_perr", ll_perr, 1'b0);
    count_busy(n);
    chk("sweep_len", n, 16);
    chk("sweep_done", ll_done, 1'b1);
    chk("sweep_led", ll_led, 1'b1);
    chk("oor_done", oor_done, 1'b1);
    for (int i = 0; i < 16; i++) begin
      rd(4'(i));
      chk("fill_rd", ll_data, 32'hFFFF_FFFF);
      chk("fill_vld", ll_vld, 1'b1);
    end
    tick();
    chk("idle_vld", ll_vld, 1'b0);
    chk("idle_hold", ll_data, 32'hFFFF_FFFF);

    // Scenario 2: byte-enable writes
    wr(4'd0, 32'h0000_00DB, 4'b1111);
    wr(4'd1, 32'h1234_5678, 4'b0101);
    wr(4'd2, 32'h0000_0000, 4'b0000);
    rd(4'd0); chk("be_full", ll_data, 32'h0000_00DB);
    rd(4'd1); chk("be_part", ll_data, 32'hFF34_FF78);
    rd(4'd2); chk("be_none", ll_data, 32'hFFFF_FFFF);
    chk("be_perr", ll_perr, 1'b0);

    // Scenario 3: same-address read/write collision returns the old word
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hA5A5_A5A5; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 4'd3;
    tick();
    wr_en = 1'b0;
    chk("coll_old", ll_data, 32'hFFFF_FFFF);
    tick();
    rd_en = 1'b0;
    chk("coll_new", ll_data, 32'hA5A5_A5A5);

    // Scenario 4: reset restarted mid-sweep, writes/reads ignored while busy
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_data", ll_data, 32'h0);
    chk("rst2_done", ll_done, 1'b0);
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'h0; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 4'd2;
    repeat (6) tick();
    chk("mid_busy", ll_busy, 1'b1);
    chk("mid_vld", ll_vld, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_busy(n);
    chk("resweep_len", n, 16);
    chk("resweep_done", ll_done, 1'b1);
    chk("resweep_vld", ll_vld, 1'b0);
    wr_en = 1'b0; rd_en = 1'b0;
    rd(4'd2); chk("busy_wr_drop", ll_data, 32'hFFFF_FFFF);
    rd(4'd0); chk("resweep_a0", ll_data, 32'hFFFF_FFFF);

    // Scenario 5: HIGH_PERFORMANCE latency and regce hold
    wr(4'd0, 32'h1111_1111, 4'hF);
    wr(4'd1, 32'h2222_2222, 4'hF);
    wr(4'd2, 32'h3333_3333, 4'hF);
    rd_en = 1'b1; rd_regce = 1'b1;
    rd_addr = 4'd0; tick();
    chk("hp_lat_vld", hp_vld, 1'b0);
    chk("ll_lat", ll_data, 32'h1111_1111);
    rd_addr = 4'd1; tick();
    chk("hp_rd0", hp_data, 32'h1111_1111);
    chk("hp_rd0_vld", hp_vld, 1'b1);
    rd_addr = 4'd2; tick();
    chk("hp_rd1", hp_data, 32'h2222_2222);
    rd_en = 1'b0; tick();
    chk("hp_rd2", hp_data, 32'h3333_3333);
    chk("hp_rd2_vld", hp_vld, 1'b1);
    rd_en = 1'b1; rd_addr = 4'd0; rd_regce = 1'b0; tick();
    chk("hp_hold_data", hp_data, 32'h3333_3333);
    chk("hp_hold_vld", hp_vld, 1'b1);
    rd_en = 1'b0; rd_regce = 1'b1; tick();
    chk("hp_release", hp_data, 32'h1111_1111);
    chk("hp_release_vld", hp_vld, 1'b1);
    tick();
    chk("hp_idle_vld", hp_vld, 1'b0);
    chk("hp_idle_data", hp_data, 32'h1111_1111);

    // Scenario 6: out-of-range access on the 12-word instance
    wr(4'd13, 32'h0000_0000, 4'hF);
    rd(4'd13);
    chk("oor_rd", oor_data, 32'hFFFF_FFFF);
    chk("oor_vld", oor_vld, 1'b1);
    chk("oor_perr", oor_perr, 1'b0);
    rd(4'd1); chk("oor_alias", oor_data, 32'h2222_2222);
`ifdef MEM_PROG_PARITY_EN
    u_oor.mem[0] = u_oor.mem[0] ^ 32'h0000_0001;
    rd(4'd0);
    chk("par_data", oor_data, 32'h1111_1110);
    chk("par_err", oor_perr, 1'b1);
    rd(4'd1);
    chk("par_clean", oor_perr, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/memoria_programa_dp.md
Name: memoria_programa_dp

Overview:
- Parametrised successor of the MIPS program memory.
- Dual-port word RAM:
  - port W loads the program with byte enables, driven by the debug/UART loader;
  - port R serves instruction fetch.
- Adds a hardware clear sweep on reset with a done flag, selectable read latency, read-first collision rules and out-of-range address handling.
- Sits between the debug unit (loader) and the IF stage.

Parameters:
- NB_COL, 4, number of byte columns per word.
- COL_WIDTH, 8, bits per column; RAM_WIDTH = NB_COL*COL_WIDTH.
- RAM_DEPTH, 2048, number of words; need not be a power of two.
- RAM_PERFORMANCE, "LOW_LATENCY", "LOW_LATENCY" (1-cycle read) or "HIGH_PERFORMANCE" (2-cycle read, output register).
- FILL_VALUE, {RAM_WIDTH{1'b1}}, word written to every address by the clear sweep.
- ADDR_W, clogb2(RAM_DEPTH-1), address width (localparam, derived).

Ports:
- i_clk  in  1  single clock, rising edge.
- i_reset  in  1  synchronous active-high reset; starts a clear sweep.
- i_wr_en  in  1  write request.
- i_wr_addr  in  ADDR_W  write word address.
- i_wr_be  in  NB_COL  byte enables; bit k writes column k.
- i_wr_data  in  RAM_WIDTH  write data.
- i_rd_en  in  1  read request.
- i_rd_addr  in  ADDR_W  read word address.
- i_rd_regce  in  1  output register clock enable (HIGH_PERFORMANCE only; ignored otherwise).
- o_rd_data  out  RAM_WIDTH  read data.
- o_rd_valid  out  1  o_rd_data holds the result of a read request.
- o_busy  out  1  clear sweep in progress; all requests ignored.
- o_clear_done  out  1  level; high once sweep completes, until next reset.
- o_led  out  1  equals o_clear_done (board indicator).
- o_parity_err  out  1  see Optional Feature.

Behaviour:
- Reset (sampled high on a rising edge):
  - state <= CLEAR, sweep counter <= 0;
  - o_busy=1, o_clear_done=0, o_led=0, o_rd_data=0, o_rd_valid=0, o_parity_err=0;
  - pipeline registers cleared.
- FSM states: CLEAR, READY.
  - CLEAR: writes FILL_VALUE to address = counter each cycle, counter++. After address RAM_DEPTH-1 is written, next state READY: o_busy 0, o_clear_done 1. The sweep takes exactly RAM_DEPTH cycles after reset deasserts.
  - READY: serves requests; stays until reset.
- Reset asserted mid-sweep restarts the sweep at address 0. Held reset keeps the counter at 0 and writes nothing.
- i_wr_en, i_rd_en and i_rd_regce are ignored while o_busy=1.
- Write: on an edge with i_wr_en=1 in READY, columns with i_wr_be[k]=1 are updated; the others keep their contents. be=0 is a no-op.
- Read, LOW_LATENCY: i_rd_en=1 at edge N gives o_rd_data = mem[addr] and o_rd_valid=1 after edge N. With no read at edge N, o_rd_valid=0 and o_rd_data holds its previous value.
- Read, HIGH_PERFORMANCE:
  - stage 1 latches at edge N;
  - the output register loads at edge N+1 only if i_rd_regce=1; o_rd_valid follows the same enable;
  - with i_rd_regce=0 the output register and valid hold.
- Collision: read and write to the same address on the same edge returns the OLD word (read-first). The new word is visible from the next read.
- Out of range (addr >= RAM_DEPTH): writes are dropped; reads return FILL_VALUE with o_rd_valid=1.
- Back-to-back reads are sustained at 1 word/cycle in both modes.

Optional Feature:
- Macro MEM_PROG_PARITY_EN.
- When defined:
  - one even-parity bit is stored per column, computed on write and on sweep;
  - on read, the parity is recomputed per column;
  - o_parity_err is asserted with the same timing as o_rd_valid when any column mismatches;
  - out-of-range reads report 0.
- When undefined: no parity storage; o_parity_err is tied to 0.

Test Plan:
- Test parameters: RAM_DEPTH=16, FILL_VALUE=32'hFFFF_FFFF, LOW_LATENCY.
- Scenario 1, sweep: pulse i_reset 1 cycle -> o_busy high exactly 16 cycles, then o_clear_done=o_led=1; reads of addr 0..15 return 32'hFFFF_FFFF.
- Scenario 2, byte write: write 32'h0000_00DB be=4'b1111 @0, then 32'h1234_5678 be=4'b0101 @1 -> read @0 = 32'h0000_00DB; read @1 = 32'hFF34_FF78.
- Scenario 3, collision: write 32'hA5A5_A5A5 @3 and read @3 on the same edge -> 32'hFFFF_FFFF; next read @3 -> 32'hA5A5_A5A5.
- Scenario 4, reset mid-sweep: reset at cycle 0, again at cycle 7 -> o_clear_done rises 16 cycles after the second reset; a write attempted @2 during the sweep is absent afterwards.
- Scenario 5, HIGH_PERFORMANCE: reads @0,@1,@2 back-to-back with regce=1 -> data appears 2 cycles after each request. Dropping regce for 1 cycle holds o_rd_data and o_rd_valid.
- Scenario 6, out of range and parity: RAM_DEPTH=12: write @13 dropped, read @13 -> FILL_VALUE. With MEM_PROG_PARITY_EN, force-flip a stored bit @0 -> o_parity_err=1 with the read data.
